// File: rtl/clock_pkg.sv
// Shared types and helpers for the hourly chime sounder.
// Holds the FSM state encoding, the top-of-minute BCD constant and the tone half-period math.
package clock_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BEEP = 1'b1
  } state_t;

  localparam logic [7:0] BCD_59 = 8'h59;

  // Number of clock cycles per half period of a square wave at tone_hz.
  function automatic int half_period(input int clk_hz, input int tone_hz);
    return clk_hz / (2 * tone_hz);
  endfunction

endpackage

// File: rtl/tone_div.sv
// Programmable half-period divider that produces the square-wave speaker drive.
// load starts a fresh wave high; dropping en parks the output low.
module tone_div #(
  parameter int TW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          en,
  input  logic [TW-1:0] half,
  output logic          tone
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (load) begin
      cnt  <= '0;
      tone <= 1'b1;
    end else if (en) begin
      if (cnt == half - TW'(1)) begin
        cnt  <= '0;
        tone <= ~tone;
      end else begin
        cnt <= cnt + TW'(1);
      end
    end else begin
      cnt  <= '0;
      tone <= 1'b0;
    end
  end

endmodule

// File: rtl/chime_sounder.sv
// Turns the hourly ALARM_Radio request into a timed square-wave beep on Speaker.
// Pitch is latched from Second on each accepted request edge: high tone only at 8'h59.
module chime_sounder
  import clock_pkg::*;
#(
  parameter int CLK_HZ   = 4000,
  parameter int LOW_HZ   = 500,
  parameter int HIGH_HZ  = 1000,
  parameter int BEEP_CYC = 2000
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic       ALARM_Radio,
  input  logic [7:0] Second,
  input  logic       Enable,
  output logic       Speaker,
  output logic       Busy,
  output logic [2:0] ChimeCnt,
  output logic       fsm_state
);

  localparam int HALF_LO  = half_period(CLK_HZ, LOW_HZ);
  localparam int HALF_HI  = half_period(CLK_HZ, HIGH_HZ);
  localparam int HALF_MAX = (HALF_LO > HALF_HI) ? HALF_LO : HALF_HI;
  localparam int TW       = $clog2(HALF_MAX) + 1;
  localparam int BW       = (BEEP_CYC > 1) ? $clog2(BEEP_CYC) : 1;

  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYC - 1);
  localparam logic [TW-1:0] HALF_LO_W = TW'(HALF_LO);
  localparam logic [TW-1:0] HALF_HI_W = TW'(HALF_HI);

  state_t        state, state_nxt;
  logic          alarm_q;
  logic          req_rise;
  logic          accept;
  logic          beep_last;
  logic          pitch_hi, pitch_nxt;
  logic          tone_run;
  logic [BW-1:0] beep_cnt, beep_cnt_nxt;
  logic [2:0]    chime_nxt;
  logic [TW-1:0] half;

  // A retrigger outranks both the natural end of a beep and the mute abort.
  always_comb begin
    req_rise     = ALARM_Radio & ~alarm_q;
    accept       = req_rise & Enable;
    beep_last    = (beep_cnt == BEEP_LAST);
    state_nxt    = state;
    beep_cnt_nxt = beep_cnt;
    pitch_nxt    = pitch_hi;
    chime_nxt    = ChimeCnt;
    tone_run     = 1'b0;

    if (accept) begin
      state_nxt    = BEEP;
      beep_cnt_nxt = '0;
      pitch_nxt    = (Second == BCD_59);
      chime_nxt    = (ChimeCnt == 3'd7) ? 3'd7 : ChimeCnt + 3'd1;
    end else begin
      case (state)
        IDLE: begin
          beep_cnt_nxt = '0;
        end
        BEEP: begin
          if (beep_last) begin
            state_nxt    = IDLE;
            beep_cnt_nxt = '0;
            if (pitch_hi) chime_nxt = 3'd0;
          end else if (!Enable) begin
            state_nxt    = IDLE;
            beep_cnt_nxt = '0;
          end else begin
            beep_cnt_nxt = beep_cnt + BW'(1);
            tone_run     = 1'b1;
          end
        end
        default: begin
          state_nxt    = IDLE;
          beep_cnt_nxt = '0;
        end
      endcase
    end
  end

  // alarm_q resets high so a request already asserted at reset release is ignored.
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state    <= IDLE;
      alarm_q  <= 1'b1;
      beep_cnt <= '0;
      pitch_hi <= 1'b0;
      ChimeCnt <= 3'd0;
    end else begin
      state    <= state_nxt;
      alarm_q  <= ALARM_Radio;
      beep_cnt <= beep_cnt_nxt;
      pitch_hi <= pitch_nxt;
      ChimeCnt <= chime_nxt;
    end
  end

  assign half      = pitch_hi ? HALF_HI_W : HALF_LO_W;
  assign Busy      = (state == BEEP);
  assign fsm_state = (state == BEEP);

  tone_div #(
    .TW(TW)
  ) u_tone_div (
    .clk  (CP),
    .rst_n(nCR),
    .load (accept),
    .en   (tone_run),
    .half (half),
    .tone (Speaker)
  );

endmodule

// File: tb/tb_chime_sounder.sv
// Self-checking bench for chime_sounder: directed scenarios plus random request traffic.
// Expected outputs come from an elapsed-time model of the beep, checked every cycle.
module tb_chime_sounder;

  localparam int CLK_HZ   = 4000;
  localparam int LOW_HZ   = 500;
  localparam int HIGH_HZ  = 1000;
  localparam int BEEP_CYC = 40;

  logic       CP;
  logic       nCR;
  logic       ALARM_Radio;
  logic [7:0] Second;
  logic       Enable;
  logic       Speaker;
  logic       Busy;
  logic [2:0] ChimeCnt;
  logic       fsm_state;

  int n_cmp;
  int n_err;

  // reference model state
  bit m_active;
  bit m_pitch;
  bit m_prev;
  int m_k;
  int m_cnt;

  chime_sounder #(
    .CLK_HZ  (CLK_HZ),
    .LOW_HZ  (LOW_HZ),
    .HIGH_HZ (HIGH_HZ),
    .BEEP_CYC(BEEP_CYC)
  ) dut (
    .CP         (CP),
    .nCR        (nCR),
    .ALARM_Radio(ALARM_Radio),
    .Second     (Second),
    .Enable     (Enable),
    .Speaker    (Speaker),
    .Busy       (Busy),
    .ChimeCnt   (ChimeCnt),
    .fsm_state  (fsm_state)
  );

  initial begin
    CP = 1'b0;
    forever #5 CP = ~CP;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_pitch  = 1'b0;
    m_prev   = 1'b1;
    m_k      = 0;
    m_cnt    = 0;
  endtask

  // One clock edge of the beep behaviour, using the inputs present at that edge.
  task automatic model_edge();
    bit rise;
    rise   = ALARM_Radio && !m_prev;
    m_prev = ALARM_Radio;
    if (rise && Enable) begin
      m_active = 1'b1;
      m_k      = 0;
      m_pitch  = (Second == 8'h59);
      if (m_cnt < 7) m_cnt++;
    end else if (m_active) begin
      if (m_k == BEEP_CYC - 1) begin
        m_active = 1'b0;
        if (m_pitch) m_cnt = 0;
      end else if (!Enable) begin
        m_active = 1'b0;
      end else begin
        m_k++;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    int  half;
    bit  exp_spk;
    half    = m_pitch ? CLK_HZ / (2 * HIGH_HZ) : CLK_HZ / (2 * LOW_HZ);
    exp_spk = m_active && (((m_k / half) % 2) == 0);
    check({tag, "_spk"}, {7'd0, Speaker}, {7'd0, exp_spk});
    check({tag, "_busy"}, {7'd0, Busy}, {7'd0, m_active});
    check({tag, "_cnt"}, {5'd0, ChimeCnt}, 8'(m_cnt));
    check({tag, "_fsm"}, {7'd0, fsm_state}, {7'd0, m_active});
  endtask

  task automatic step(input logic a, input logic e, input logic [7:0] s, input string tag);
    @(negedge CP);
    ALARM_Radio = a;
    Enable      = e;
    Second      = s;
    @(posedge CP);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic async_reset();
    @(negedge CP);
    #2 nCR = 1'b0;
    #1;
    model_reset();
    check_outputs("arst");
    repeat (3) @(posedge CP);
    #1 check_outputs("arst_hold");
    @(negedge CP);
    ALARM_Radio = 1'b1;
    nCR         = 1'b1;
  endtask

  initial begin
    logic       a;
    logic [7:0] s;
    int         r;
    n_cmp = 0;
    n_err = 0;
    nCR = 1'b0;
    ALARM_Radio = 1'b1;
    Enable = 1'b1;
    Second = 8'h00;
    model_reset();
    repeat (3) @(posedge CP);
    #1 check_outputs("rst");
    @(negedge CP);
    nCR = 1'b1;

    // request high through reset release: silent
    repeat (100) step(1'b1, 1'b1, 8'h55, "hold");

    // single low beep
    step(1'b0, 1'b1, 8'h55, "low");
    repeat (60) step(1'b1, 1'b1, 8'h55, "low");
    repeat (40) step(1'b0, 1'b1, 8'h55, "low");

    // full hourly sequence 55..59
    for (int i = 0; i < 5; i++) begin
      s = 8'h55 + 8'(i);
      repeat (50) step(1'b1, 1'b1, s, "seq");
      repeat (50) step(1'b0, 1'b1, s, "seq");
    end

    // retrigger at high pitch 10 cycles into a low beep
    step(1'b1, 1'b1, 8'h55, "retrig");
    repeat (9) step(1'b1, 1'b1, 8'h55, "retrig");
    step(1'b0, 1'b1, 8'h59, "retrig");
    repeat (50) step(1'b1, 1'b1, 8'h59, "retrig");
    step(1'b0, 1'b1, 8'h55, "retrig");

    // mute mid-beep, then a dropped edge while muted
    step(1'b1, 1'b1, 8'h56, "mute");
    repeat (14) step(1'b1, 1'b1, 8'h56, "mute");
    repeat (5) step(1'b1, 1'b0, 8'h56, "mute");
    repeat (5) step(1'b0, 1'b0, 8'h56, "mute");
    repeat (5) step(1'b1, 1'b0, 8'h57, "mute");
    repeat (10) step(1'b1, 1'b1, 8'h57, "mute");
    step(1'b0, 1'b1, 8'h57, "mute");

    // saturation of ChimeCnt, then cleared by a completed high beep
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, 8'h57, "sat");
      repeat (3) step(1'b0, 1'b1, 8'h57, "sat");
    end
    repeat (45) step(1'b0, 1'b1, 8'h57, "sat");
    step(1'b1, 1'b1, 8'h59, "sat");
    repeat (45) step(1'b0, 1'b1, 8'h59, "sat");

    // async reset mid-beep
    step(1'b1, 1'b1, 8'h55, "ar");
    repeat (12) step(1'b1, 1'b1, 8'h55, "ar");
    async_reset();
    repeat (20) step(1'b1, 1'b1, 8'h55, "ar_post");
    step(1'b0, 1'b1, 8'h59, "ar_post");
    repeat (60) step(1'b1, 1'b1, 8'h59, "ar_post");

    // random traffic
    a = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) a = ~a;
      r = int'($urandom_range(0, 7));
      s = (r < 5) ? 8'h55 + 8'(r) : 8'($urandom_range(0, 255));
      step(a, ($urandom_range(0, 29) != 0), s, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/chime_sounder.md
Name: chime_sounder

Overview:
Consumes the hourly time-signal request ALARM_Radio produced by the chime generator and drives the speaker pin with a timed square-wave beep.
- Pitch is chosen from the BCD Second value latched at each request edge: low tone for 8'h55..8'h58, high tone for 8'h59.
- Sits between the chime generator and the top-level speaker output. It replaces the ad-hoc ANDing of ALARM_Radio with the _500Hz/_1kHz nets.

Parameters:
CLK_HZ, 4000, frequency of CP in Hz
LOW_HZ, 500, low-tone frequency; CLK_HZ/(2*LOW_HZ) must be an integer >= 1
HIGH_HZ, 1000, high-tone frequency; CLK_HZ/(2*HIGH_HZ) must be an integer >= 1
BEEP_CYC, 2000, beep length in CP cycles (default 0.5 s)

Ports:
CP  input  1  system clock, rising edge
nCR  input  1  asynchronous active-low reset
ALARM_Radio  input  1  chime request level from chime generator; synchronous to CP
Second  input  8  BCD seconds {tens,units}, sampled on the request edge
Enable  input  1  chime enable (user mute when 0)
Speaker  output  1  square-wave drive to buzzer
Busy  output  1  high while a beep is sounding
ChimeCnt  output  3  beeps accepted since the last completed high beep

Behaviour:
- Reset (nCR=0, async): state=IDLE, Speaker=0, Busy=0, ChimeCnt=0, tone and beep counters=0.
- The ALARM_Radio history register resets to 1, so a request already high at reset release does not trigger a beep.
- Request edge: req_rise = ALARM_Radio & ~alarm_q. alarm_q is updated every cycle. Accepted only when Enable=1.
- States: IDLE, BEEP.
  - IDLE -> BEEP on accepted req_rise.
  - BEEP -> IDLE when beep_cnt reaches BEEP_CYC-1, or when Enable=0.
- On acceptance:
  - pitch_hi <= (Second==8'h59).
  - beep_cnt <= 0, tone_cnt <= 0, Speaker <= 1.
  - ChimeCnt <= ChimeCnt+1, saturating at 7.
  - Busy goes high in the cycle after the edge cycle.
- In BEEP:
  - beep_cnt increments each cycle.
  - tone_cnt counts 0..HALF-1, where HALF = CLK_HZ/(2*HIGH_HZ) if pitch_hi, else CLK_HZ/(2*LOW_HZ).
  - At HALF-1, Speaker toggles and tone_cnt returns to 0.
- Beep length: Speaker is active for exactly BEEP_CYC cycles, counted from the first cycle Speaker=1.
  - At beep end: Speaker=0, Busy=0 in the same cycle as the state returns to IDLE.
  - If pitch_hi was 1 at beep end, ChimeCnt clears to 0.
- Retrigger: req_rise during BEEP with Enable=1 restarts the beep (counters to 0, Speaker=1, pitch re-latched, ChimeCnt+1). The old beep is truncated.
- Abort: Enable=0 during BEEP gives IDLE next cycle with Speaker=0 and Busy=0. ChimeCnt is kept unchanged.
- Edges while Enable=0 are dropped and not queued.
- Simultaneous beep end and req_rise: the retrigger wins. The beep restarts and ChimeCnt is not cleared.
- Second not 8'h55..8'h59 at the edge: low pitch. No error is raised.
- Counter widths: $clog2(BEEP_CYC) and $clog2(max HALF)+1. No wrap is possible inside one beep.

Decomposition:
- Shared package clock_pkg:
  - state enum {IDLE, BEEP}.
  - Constant BCD_59 = 8'h59.
  - Function half_period(clk_hz, tone_hz).
- One natural sub-module: tone_div. It is a programmable half-period divider with load, enable and a HALF input, and produces the Speaker toggle.

Test Plan:
(Bench uses CLK_HZ=4000, BEEP_CYC=40, so low HALF=4 and high HALF=2.)
1. Reset with ALARM_Radio=1, release nCR -> no beep; Speaker=0, Busy=0, ChimeCnt=0 for 100 cycles.
2. Enable=1, Second=8'h55, pulse ALARM_Radio high for 60 cycles -> Speaker square wave with period 8 cycles for exactly 40 cycles; Busy high for 40 cycles; ChimeCnt=1.
3. Full sequence of edges at Second 8'h55, 56, 57, 58, 59 spaced 100 cycles apart -> four low beeps (period 8) and one high beep (period 4). ChimeCnt reads 1..5 and is 0 after the high beep ends.
4. Second req_rise 10 cycles into a low beep, with Second=8'h59 -> beep restarts at high pitch and lasts 40 cycles from the restart; ChimeCnt is incremented.
5. Enable=0 at cycle 15 of a beep -> Speaker=0 and Busy=0 the next cycle. A req_rise while Enable=0 produces no beep and leaves ChimeCnt unchanged.
6. Assert nCR mid-beep (async, between clock edges) -> Speaker, Busy and ChimeCnt go to 0 immediately. After release, ALARM_Radio still high gives no beep; the next fresh rising edge beeps normally.
